// File: rtl/zap_fetch_pkg.sv
// Shared fetch-path types: one queued fetch entry (instr, pc, abort) and reset constants.
package zap_fetch_pkg;

    localparam int ENTRY_W   = 65;
    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = 32;
    localparam int ABORT_BIT = 64;

    localparam logic [31:0] ABORT_PAYLOAD   = 32'd0;
    localparam logic [31:0] RESET_PC_PLUS_8 = 32'd8;

    // Packed MSB-first so abort lands on bit 64, pc on [63:32], instr on [31:0].
    typedef struct packed {
        logic        abort;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/zap_prefetch_buffer_if.sv
// Fetch-to-decode bus of the prefetch buffer; the buffer uses the slave modport.
interface zap_prefetch_buffer_if;
    logic [31:0] i_instruction;
    logic        i_valid;
    logic        i_instr_abort;
    logic [31:0] i_pc_plus_8;
    logic        o_stall_to_fetch;
    logic [31:0] o_instruction;
    logic        o_valid;
    logic        o_instr_abort;
    logic [31:0] o_pc_plus_8_ff;

    modport slave (
        input  i_instruction, i_valid, i_instr_abort, i_pc_plus_8,
        output o_stall_to_fetch, o_instruction, o_valid, o_instr_abort, o_pc_plus_8_ff
    );
    modport master (
        output i_instruction, i_valid, i_instr_abort, i_pc_plus_8,
        input  o_stall_to_fetch, o_instruction, o_valid, o_instr_abort, o_pc_plus_8_ff
    );
endinterface

// File: rtl/zap_sync_fifo_core.sv
// Synchronous FIFO of fetch entries: storage, wrapping pointers, occupancy count.
module zap_sync_fifo_core
    import zap_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_reset | flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; a flush only needs the pointers cleared.
    always_ff @(posedge i_clk) begin
        if (do_push & ~(i_reset | flush)) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/zap_prefetch_buffer.sv
// Prefetch queue between fetch and decode with a registered decode-side stage.
// Define ZAP_PREFETCH_BYPASS_EN to let a word reach decode directly when the queue is empty.
module zap_prefetch_buffer
    import zap_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear_from_writeback,
    input  logic i_data_stall,
    input  logic i_clear_from_alu,
    input  logic i_stall_from_shifter,
    input  logic i_stall_from_issue,
    input  logic i_stall_from_decode,
    zap_prefetch_buffer_if.slave bus
);
    fetch_entry_t in_entry, head, out_q;
    logic         out_vld, abort_lock;
    logic         freeze, clear, stall, push, bypass, fifo_push, full, empty;

    assign freeze = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
    // A data stall outranks the ALU clear, so that clear is masked rather than deferred.
    assign clear  = i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
    assign stall  = full | abort_lock;
    assign push   = bus.i_valid & ~stall & ~clear;

`ifdef ZAP_PREFETCH_BYPASS_EN
    assign bypass = push & empty & ~freeze;
`else
    assign bypass = 1'b0;
`endif
    assign fifo_push = push & ~bypass;

    assign in_entry = '{abort: bus.i_instr_abort, pc: bus.i_pc_plus_8, instr: bus.i_instruction};

    zap_sync_fifo_core #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .flush   (clear),
        .push    (fifo_push),
        .pop     (~clear & ~freeze),
        .wdata   (in_entry),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_vld <= 1'b0;
            out_q   <= '{abort: 1'b0, pc: RESET_PC_PLUS_8, instr: '0};
        end else if (clear) begin
            out_vld     <= 1'b0;
            out_q.abort <= 1'b0;
            out_q.instr <= '0;
        end else if (~freeze) begin
            if (~empty) begin
                out_vld <= 1'b1;
                out_q   <= head;
            end else if (bypass) begin
                out_vld <= 1'b1;
                out_q   <= in_entry;
            end else begin
                out_vld     <= 1'b0;
                out_q.abort <= 1'b0;
                out_q.instr <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset | clear)               abort_lock <= 1'b0;
        else if (push & bus.i_instr_abort) abort_lock <= 1'b1;
    end

    assign bus.o_stall_to_fetch = stall;
    assign bus.o_valid          = out_vld;
    assign bus.o_instruction    = out_q.instr;
    assign bus.o_instr_abort    = out_q.abort;
    assign bus.o_pc_plus_8_ff   = out_q.pc;

endmodule

// File: tb/tb_zap_prefetch_buffer.sv
// Scoreboard bench for zap_prefetch_buffer against a queue-based reference model.
module tb_zap_prefetch_buffer;
    import zap_fetch_pkg::*;

    localparam int DEPTH = 4;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_clear_from_writeback = 1'b0, i_data_stall = 1'b0, i_clear_from_alu = 1'b0;
    logic i_stall_from_shifter = 1'b0, i_stall_from_issue = 1'b0, i_stall_from_decode = 1'b0;

    zap_prefetch_buffer_if bus ();

    zap_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_stall_from_shifter   (i_stall_from_shifter),
        .i_stall_from_issue     (i_stall_from_issue),
        .i_stall_from_decode    (i_stall_from_decode),
        .bus                    (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0, fails = 0;
    bit mon_en = 1'b0;

    fetch_entry_t fetch_q[$];   // words fetch still has to deliver
    fetch_entry_t mq[$];        // words sitting in the buffer
    fetch_entry_t expq[$];      // accepted words decode has not yet seen
    bit           lock_m = 1'b0, vld_m = 1'b0, acc_m = 1'b0, loaded_m = 1'b0;
    logic [31:0]  instr_m = '0, pc_m = 32'd8;
    bit           abort_m = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue semantics straight from the behavioural rules.
    always @(posedge i_clk) begin : model
        automatic fetch_entry_t e, h;
        automatic bit clr, frz, stl, acc, byp;
        e   = '{abort: bus.i_instr_abort, pc: bus.i_pc_plus_8, instr: bus.i_instruction};
        stl = (mq.size() == DEPTH) || lock_m;
        clr = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
        frz = i_data_stall || i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode;
        acc = bus.i_valid && !stl && !clr && !i_reset;
        acc_m = acc;
        loaded_m = 1'b0;
        byp = 1'b0;
        if (i_reset) begin
            mq.delete(); expq.delete();
            lock_m = 0; vld_m = 0; instr_m = 0; abort_m = 0; pc_m = 32'd8;
        end else if (clr) begin
            mq.delete(); expq.delete();
            lock_m = 0; vld_m = 0; instr_m = 0; abort_m = 0;
        end else begin
            if (!frz) begin
                if (mq.size() > 0) begin
                    h = mq.pop_front();
                    vld_m = 1; instr_m = h.instr; pc_m = h.pc; abort_m = h.abort; loaded_m = 1;
                end
`ifdef ZAP_PREFETCH_BYPASS_EN
                else if (acc) begin
                    byp = 1;
                    vld_m = 1; instr_m = e.instr; pc_m = e.pc; abort_m = e.abort; loaded_m = 1;
                end
`endif
                else begin
                    vld_m = 0; instr_m = 0; abort_m = 0;
                end
            end
            if (acc) begin
                if (!byp) mq.push_back(e);
                expq.push_back(e);
                if (e.abort) lock_m = 1;
            end
        end
    end

    // Fetch side: hold the head word until the model says it was taken.
    initial begin
        bus.i_valid = 0; bus.i_instruction = 0; bus.i_instr_abort = 0; bus.i_pc_plus_8 = 0;
        forever begin
            @(posedge i_clk); #1;
            if (acc_m && fetch_q.size() > 0) fetch_q.delete(0);
            if (fetch_q.size() > 0) begin
                bus.i_valid = 1; bus.i_instruction = fetch_q[0].instr;
                bus.i_instr_abort = fetch_q[0].abort; bus.i_pc_plus_8 = fetch_q[0].pc;
            end else begin
                bus.i_valid = 0; bus.i_instruction = 0; bus.i_instr_abort = 0; bus.i_pc_plus_8 = 0;
            end
        end
    end

    // Monitor: a newly loaded output must match the oldest outstanding accepted word.
    always @(negedge i_clk) begin
        if (mon_en) begin
            check("stall_to_fetch", 32'(bus.o_stall_to_fetch), 32'((mq.size() == DEPTH) || lock_m));
            check("valid", 32'(bus.o_valid), 32'(vld_m));
            if (loaded_m) begin
                if (expq.size() == 0) begin
                    check("scoreboard_underflow", 32'(1), 32'(0));
                end else begin
                    automatic fetch_entry_t x = expq.pop_front();
                    check("instr", bus.o_instruction, x.instr);
                    check("pc", bus.o_pc_plus_8_ff, x.pc);
                    check("abort", 32'(bus.o_instr_abort), 32'(x.abort));
                end
            end else begin
                check("instr_hold", bus.o_instruction, instr_m);
                check("pc_hold", bus.o_pc_plus_8_ff, pc_m);
                check("abort_hold", 32'(bus.o_instr_abort), 32'(abort_m));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bit ab);
        fetch_q.push_back('{abort: ab, pc: pc, instr: ab ? ABORT_PAYLOAD : instr});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((fetch_q.size() > 0 || mq.size() > 0) && n < budget) begin
            if (lock_m) begin i_clear_from_alu = 1; tick(1); i_clear_from_alu = 0; end
            tick(1);
            n++;
        end
        tick(3);
        check("drain_timeout", 32'(n < budget), 32'(1));
    endtask

    initial begin
        tick(2);
        mon_en = 1;
        tick(1);
        i_reset = 0;
        tick(3);

        // Single word latency from idle.
        send(32'hE1A00000, 32'h8, 0);
        tick(6);

        // Fill to full behind a decode stall; fifth word is held, then all drain in order.
        i_stall_from_decode = 1;
        for (int i = 0; i < 5; i++) send(32'hA000_0000 + i, 32'h100 + 4 * i, 0);
        tick(8);
        i_stall_from_decode = 0;
        wait_drain(100);

        // Abort word locks the queue until an ALU clear.
        send(0, 32'h200, 1);
        send(32'hB000_0001, 32'h204, 0);
        send(32'hB000_0002, 32'h208, 0);
        tick(8);
        i_clear_from_alu = 1; tick(1); i_clear_from_alu = 0;
        wait_drain(100);

        // Data stall masks ALU clear; writeback clear still flushes.
        i_stall_from_decode = 1;
        for (int i = 0; i < 3; i++) send(32'hC000_0000 + i, 32'h300 + 4 * i, 0);
        tick(6);
        i_data_stall = 1; i_clear_from_alu = 1; tick(1); i_clear_from_alu = 0;
        tick(2);
        i_clear_from_writeback = 1; tick(1); i_clear_from_writeback = 0;
        i_data_stall = 0; i_stall_from_decode = 0;
        tick(2);

        // Pointer wrap under random decode stalls.
        for (int i = 1; i <= 20; i++) send(i, 32'h1000 + 4 * i, 0);
        for (int c = 0; c < 400 && (fetch_q.size() > 0 || mq.size() > 0); c++) begin
            i_stall_from_decode = ($urandom_range(0, 2) == 0);
            tick(1);
        end
        i_stall_from_decode = 0;
        wait_drain(100);

        // Random mix of stalls, clears, aborts and an occasional reset.
        for (int c = 0; c < 600; c++) begin
            i_stall_from_decode    = ($urandom_range(0, 3) == 0);
            i_stall_from_issue     = ($urandom_range(0, 7) == 0);
            i_stall_from_shifter   = ($urandom_range(0, 11) == 0);
            i_data_stall           = ($urandom_range(0, 11) == 0);
            i_clear_from_alu       = ($urandom_range(0, 19) == 0);
            i_clear_from_writeback = ($urandom_range(0, 39) == 0);
            i_reset                = ($urandom_range(0, 199) == 0);
            if (fetch_q.size() < 3 && $urandom_range(0, 1) == 1)
                send($urandom, $urandom, $urandom_range(0, 15) == 0);
            tick(1);
        end
        i_stall_from_decode = 0; i_stall_from_issue = 0; i_stall_from_shifter = 0;
        i_data_stall = 0; i_clear_from_alu = 0; i_clear_from_writeback = 0; i_reset = 0;
        wait_drain(200);

        check("scoreboard_empty", 32'(expq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/zap_prefetch_buffer.md
Name: zap_prefetch_buffer

Overview:
- Small synchronous instruction queue between the fetch stage and decode.
- Absorbs back-pressure from decode/issue/shifter/data stalls, so the I-cache frontend keeps streaming while downstream is frozen.
- Each entry carries instruction word, abort flag and PC+8/PC+4 value; entries leave in order to decode through a registered output stage.
- Flushed by writeback and ALU clears using the same priority order as the rest of the pipeline.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_clear_from_writeback  in  1  flush, highest priority.
- i_data_stall  in  1  freeze output stage.
- i_clear_from_alu  in  1  flush.
- i_stall_from_shifter  in  1  freeze output stage.
- i_stall_from_issue  in  1  freeze output stage.
- i_stall_from_decode  in  1  freeze output stage, lowest priority.
- i_instruction  in  32  instruction from fetch.
- i_valid  in  1  fetch output valid.
- i_instr_abort  in  1  fetch abort flag; payload is 32'd0.
- i_pc_plus_8  in  32  PC+8 (ARM) or PC+4 (Thumb) from fetch.
- o_stall_to_fetch  out  1  fetch must hold its outputs; combinational from registered state.
- o_instruction  out  32  to decode.
- o_valid  out  1  to decode.
- o_instr_abort  out  1  to decode.
- o_pc_plus_8_ff  out  32  to decode.

Behaviour:
- Reset: o_valid=0, o_instruction=0, o_instr_abort=0, o_pc_plus_8_ff=32'd8. Pointers and count=0. abort_lock=0. Storage contents don't care.
- Signal definitions:
  - freeze = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode.
  - full = (count==DEPTH).
  - o_stall_to_fetch = full | abort_lock.
- Push: accepted iff i_valid & !o_stall_to_fetch & no clear active. Fetch holds its outputs while o_stall_to_fetch=1, so a held word is enqueued exactly once.
- Abort push: an entry with i_instr_abort=1 sets abort_lock. Further pushes are blocked until a clear.
- Pop: when no clear and !freeze, output regs load the head entry if count>0 (o_valid=1); otherwise o_valid=0, o_instr_abort=0, o_instruction=0. o_pc_plus_8_ff holds its last value when nothing is popped.
- Freeze: output regs hold. Pushes continue until full.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH. count is PTR_W+1 bits and never exceeds DEPTH.
- Clear priority, cycle by cycle:
  - i_reset > i_clear_from_writeback > i_data_stall > i_clear_from_alu > remaining stalls.
  - Clear effect: count=0, pointers=0, abort_lock=0, o_valid=0, o_instr_abort=0, o_instruction=0. o_pc_plus_8_ff unchanged. The push in that cycle is dropped.
  - i_clear_from_alu is ignored while i_data_stall=1.
- Latency without bypass: a word accepted in cycle N appears on outputs at N+2 if the queue was empty and there is no freeze.
- Reset mid-stream discards all entries. No partial state survives.

Optional Feature:
- Macro: ZAP_PREFETCH_BYPASS_EN.
- Defined: when count==0, !freeze, no clear, and a push is accepted, the incoming word loads the output regs directly in the same edge. It is not written into the queue. Latency is 1 cycle.
- Undefined: all words pass through storage (latency 2). Behaviour is otherwise identical, including ordering and abort_lock.

Decomposition:
- Shared package zap_fetch_pkg holds:
  - ENTRY_W=65 and field offsets (instr[31:0], pc[63:32], abort[64]).
  - ABORT_PAYLOAD=32'd0.
  - RESET_PC_PLUS_8=32'd8.
- One natural sub-module, zap_sync_fifo_core: storage array, read/write pointers and count, with push/pop/flush inputs and full/empty outputs.
- The top level keeps clear/stall priority, abort_lock, bypass and the output register.

Test Plan:
- Reset, then push 0xE1A00000/pc 0x8 with no stalls -> o_valid=1 with those values at N+2 (N+1 with bypass). Before that, outputs stay 0/0/8.
- Hold i_stall_from_decode=1 and push 5 words with DEPTH=4 -> o_stall_to_fetch rises after the 4th accept and the 5th is held. Release the stall -> 5 words reach decode in order, with no duplicate and no loss.
- Push a word with i_instr_abort=1, instruction 0 -> abort_lock=1 and o_stall_to_fetch=1. The abort entry reaches decode with o_instr_abort=1. Subsequent i_valid words are not accepted until i_clear_from_alu, after which count=0 and o_valid=0.
- Queue holds 3 entries, assert i_data_stall and i_clear_from_alu together -> no flush and outputs hold. Assert i_clear_from_writeback with i_data_stall -> flush; o_valid=0 next cycle.
- Count=DEPTH, un-freeze with i_valid=1 in the same cycle -> pop occurs and push is rejected (o_stall_to_fetch was 1). Next cycle the push is accepted and count stays DEPTH-1+1.
- Pointer wrap: stream 20 sequential words (0x1..0x14) with random decode stalls -> decode sees 0x1..0x14 exactly once, in order.
